gate_sweep_checker: RTL and testbench



---
 rtl/gate_sweep_pkg.sv | 49 ++++
 rtl/gate_sweep_checker_ref_model.sv | 22 ++
 rtl/gate_sweep_checker.sv | 141 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate truth-table sweeper: gate function codes,
// sweep FSM states and the reference reduction used by RTL and benches.
package gate_sweep_pkg;

   localparam logic [2:0] OP_NAND = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;

   localparam int MAX_N_IN = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CHECK,
      DONE
   } state_t;

   // Reduces only the low nIn bits of vec, so callers may zero-extend freely.
   function automatic logic gate_expected(input logic [2:0] op,
                                          input logic [MAX_N_IN-1:0] vec,
                                          input int nIn);
      logic allOnes;
      logic anyOne;
      logic parity;
      allOnes = 1'b1;
      anyOne  = 1'b0;
      parity  = 1'b0;
      for (int i = 0; i < MAX_N_IN; i++) begin
         if (i < nIn) begin
            allOnes = allOnes & vec[i];
            anyOne  = anyOne | vec[i];
            parity  = parity ^ vec[i];
         end
      end
      case (op)
         OP_NAND: return ~allOnes;
         OP_AND:  return allOnes;
         OP_OR:   return anyOne;
         OP_NOR:  return ~anyOne;
         OP_XOR:  return parity;
         OP_XNOR: return ~parity;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/gate_sweep_checker_ref_model.sv
// Combinational reference gate: maps the current stimulus vector to the
// output the gate under test is expected to produce.
module gate_ref_model
   import gate_sweep_pkg::*;
#(
   parameter int         N_IN = 2,
   parameter logic [2:0] OP   = OP_NAND
) (
   input  logic [N_IN-1:0] stim_i,
   output logic            exp_y_o
);

   logic [MAX_N_IN-1:0] vecWide;

   always_comb begin
      vecWide             = '0;
      vecWide[N_IN-1:0]   = stim_i;
   end

   assign exp_y_o = gate_expected(OP, vecWide, N_IN);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweeper/checker for a single combinational gate.
// Optional MISMATCH_MAP_EN adds a per-vector mismatch bitmap output.
module gate_sweep_checker
   import gate_sweep_pkg::*;
#(
   parameter int         N_IN   = 2,
   parameter int         SETTLE = 1,
   parameter logic [2:0] OP     = OP_NAND
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   output logic [N_IN-1:0]   stim_o,
   input  logic              dut_y_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [N_IN:0]     err_count_o,
   output logic [N_IN-1:0]   first_fail_vec_o,
   output logic              first_fail_valid_o
`ifdef MISMATCH_MAP_EN
   ,
   output logic [(2**N_IN)-1:0] mismatch_map_o
`endif
);

   localparam int              CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0] STIM_LAST = '1;

   state_t            state_q;
   logic [N_IN-1:0]   stim_q;
   logic [CNT_W-1:0]  settleCnt_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [N_IN:0]     errCount_q;
   logic [N_IN:0]     errCount_d;
   logic [N_IN-1:0]   firstFailVec_q;
   logic              firstFailValid_q;
   logic              expY;
   logic              mismatch;
`ifdef MISMATCH_MAP_EN
   logic [(2**N_IN)-1:0] mismatchMap_q;
`endif

   gate_ref_model #(
      .N_IN (N_IN),
      .OP   (OP)
   ) u_ref (
      .stim_i  (stim_q),
      .exp_y_o (expY)
   );

   // Case inequality so an undriven or unknown gate output counts as a failure.
   always_comb begin
      mismatch   = (dut_y_i !== expY);
      errCount_d = errCount_q + {{N_IN{1'b0}}, mismatch};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         stim_q           <= '0;
         settleCnt_q      <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         errCount_q       <= '0;
         firstFailVec_q   <= '0;
         firstFailValid_q <= 1'b0;
`ifdef MISMATCH_MAP_EN
         mismatchMap_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  stim_q           <= '0;
                  settleCnt_q      <= '0;
                  errCount_q       <= '0;
                  firstFailVec_q   <= '0;
                  firstFailValid_q <= 1'b0;
                  done_q           <= 1'b0;
                  pass_q           <= 1'b0;
                  busy_q           <= 1'b1;
                  state_q          <= WAIT;
`ifdef MISMATCH_MAP_EN
                  mismatchMap_q    <= '0;
`endif
               end
            end
            WAIT: begin
               if (settleCnt_q == CNT_LAST) begin
                  settleCnt_q <= '0;
                  state_q     <= CHECK;
               end else begin
                  settleCnt_q <= settleCnt_q + CNT_W'(1);
               end
            end
            CHECK: begin
               errCount_q <= errCount_d;
               if (mismatch && !firstFailValid_q) begin
                  firstFailVec_q   <= stim_q;
                  firstFailValid_q <= 1'b1;
               end
`ifdef MISMATCH_MAP_EN
               if (mismatch) begin
                  mismatchMap_q[stim_q] <= 1'b1;
               end
`endif
               // The last vector ends the sweep; stim parks at all-ones.
               if (stim_q == STIM_LAST) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (errCount_d == '0);
                  state_q <= DONE;
               end else begin
                  stim_q  <= stim_q + N_IN'(1);
                  state_q <= WAIT;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign stim_o             = stim_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign pass_o             = pass_q;
   assign err_count_o        = errCount_q;
   assign first_fail_vec_o   = firstFailVec_q;
   assign first_fail_valid_o = firstFailValid_q;
`ifdef MISMATCH_MAP_EN
   assign mismatch_map_o     = mismatchMap_q;
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench: a 2-input NAND checker and a 3-input XOR checker driven
// by modelled gates with injected faults, checked against a truth-table model.
module tb_gate_sweep_checker;
   import gate_sweep_pkg::*;

   localparam int NA = 2;
   localparam int SA = 1;
   localparam int NB = 3;
   localparam int SB = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          startA = 1'b0;
   logic [NA-1:0] stimA;
   logic          dutYA;
   logic          busyA, doneA, passA, ffValidA;
   logic [NA:0]   errA;
   logic [NA-1:0] ffVecA;

   logic          startB = 1'b0;
   logic [NB-1:0] stimB;
   logic          dutYB;
   logic          busyB, doneB, passB, ffValidB;
   logic [NB:0]   errB;
   logic [NB-1:0] ffVecB;
`ifdef MISMATCH_MAP_EN
   logic [3:0]    mapA;
   logic [7:0]    mapB;
`endif

   // Gate under test models: 0 = healthy with per-vector flips, 1 = stuck-1, 2 = stuck-0.
   int         modeA = 0;
   logic [3:0] faultMaskA = '0;
   logic [7:0] faultMaskB = '0;

   int testsRun = 0;
   int testsFailed = 0;

   always_comb begin
      case (modeA)
         1:       dutYA = 1'b1;
         2:       dutYA = 1'b0;
         default: dutYA = (~&stimA) ^ faultMaskA[stimA];
      endcase
   end

   assign dutYB = (^stimB) ^ faultMaskB[stimB];

   gate_sweep_checker #(.N_IN(NA), .SETTLE(SA), .OP(OP_NAND)) dutA (
      .clk                (clk),
      .rst_n              (rst_n),
      .start_i            (startA),
      .stim_o             (stimA),
      .dut_y_i            (dutYA),
      .busy_o             (busyA),
      .done_o             (doneA),
      .pass_o             (passA),
      .err_count_o        (errA),
      .first_fail_vec_o   (ffVecA),
      .first_fail_valid_o (ffValidA)
`ifdef MISMATCH_MAP_EN
      ,
      .mismatch_map_o     (mapA)
`endif
   );

   gate_sweep_checker #(.N_IN(NB), .SETTLE(SB), .OP(OP_XOR)) dutB (
      .clk                (clk),
      .rst_n              (rst_n),
      .start_i            (startB),
      .stim_o             (stimB),
      .dut_y_i            (dutYB),
      .busy_o             (busyB),
      .done_o             (doneB),
      .pass_o             (passB),
      .err_count_o        (errB),
      .first_fail_vec_o   (ffVecB),
      .first_fail_valid_o (ffValidB)
`ifdef MISMATCH_MAP_EN
      ,
      .mismatch_map_o     (mapB)
`endif
   );

   // Truth tables from the gate definitions: NAND2 is low only for 11, XOR3 is odd parity.
   function automatic bit refNand2(int v);
      return v != 3;
   endfunction

   function automatic bit refXor3(int v);
      return ($countones(v) % 2) == 1;
   endfunction

   function automatic bit gateOutA(int v);
      if (modeA == 1) return 1'b1;
      if (modeA == 2) return 1'b0;
      return refNand2(v) ^ faultMaskA[v];
   endfunction

   task automatic applyReset();
      rst_n = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      applyReset();
      testsRun++;
      if (stimA !== '0 || busyA !== 1'b0 || doneA !== 1'b0 || passA !== 1'b0 ||
          errA !== '0 || ffVecA !== '0 || ffValidA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_A: stim=%0d busy=%b done=%b pass=%b err=%0d ffv=%0d ffvalid=%b, required all zero",
                  stimA, busyA, doneA, passA, errA, ffVecA, ffValidA);
      end
      testsRun++;
      if (stimB !== '0 || busyB !== 1'b0 || doneB !== 1'b0 || passB !== 1'b0 ||
          errB !== '0 || ffVecB !== '0 || ffValidB !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_B: stim=%0d busy=%b done=%b pass=%b err=%0d ffv=%0d ffvalid=%b, required all zero",
                  stimB, busyB, doneB, passB, errB, ffVecB, ffValidB);
      end
`ifdef MISMATCH_MAP_EN
      testsRun++;
      if (mapA !== '0 || mapB !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_map: A=%b B=%b, required 0", mapA, mapB);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One full sweep of checker A; optionally pulses start again mid-sweep.
   task automatic sweepA(input string tag, input bit pulseMid);
      int total;
      int expErr;
      int expFirst;
      bit expValid;
      logic [3:0] expMap;
      total = 4 * (SA + 1);
      expErr = 0;
      expFirst = 0;
      expValid = 1'b0;
      expMap = '0;
      for (int v = 0; v < 4; v++) begin
         if (gateOutA(v) != refNand2(v)) begin
            expErr++;
            expMap[v] = 1'b1;
            if (!expValid) begin
               expValid = 1'b1;
               expFirst = v;
            end
         end
      end
      @(posedge clk); #1;
      startA = 1'b1;
      @(posedge clk); #1;
      startA = 1'b0;
      for (int j = 0; j < total; j++) begin
         testsRun++;
         if (stimA !== NA'(j / (SA + 1)) || busyA !== 1'b1 || doneA !== 1'b0 ||
             (j == 0 && (errA !== '0 || ffValidA !== 1'b0 || passA !== 1'b0))) begin
            testsFailed++;
            $display("[TB] FAIL %s_cycle%0d: stim=%0d busy=%b done=%b err=%0d ffvalid=%b, required stim=%0d busy=1 done=0",
                     tag, j, stimA, busyA, doneA, errA, ffValidA, j / (SA + 1));
         end
         if (pulseMid && j == 2) startA = 1'b1;
         if (j == 3) startA = 1'b0;
         @(posedge clk); #1;
      end
      testsRun++;
      if (doneA !== 1'b1 || busyA !== 1'b0 || stimA !== NA'(3)) begin
         testsFailed++;
         $display("[TB] FAIL %s_done: done=%b busy=%b stim=%0d, required done=1 busy=0 stim=3",
                  tag, doneA, busyA, stimA);
      end
      testsRun++;
      if (errA !== (NA+1)'(expErr) || passA !== (expErr == 0) ||
          ffValidA !== expValid || ffVecA !== NA'(expFirst)) begin
         testsFailed++;
         $display("[TB] FAIL %s_result: err=%0d pass=%b ffvalid=%b ffv=%0d, required err=%0d pass=%b ffvalid=%b ffv=%0d",
                  tag, errA, passA, ffValidA, ffVecA, expErr, expErr == 0, expValid, expFirst);
      end
`ifdef MISMATCH_MAP_EN
      testsRun++;
      if (mapA !== expMap) begin
         testsFailed++;
         $display("[TB] FAIL %s_map: map=%b, required %b", tag, mapA, expMap);
      end
`endif
      @(posedge clk); #1;
      testsRun++;
      if (doneA !== 1'b1 || stimA !== NA'(3)) begin
         testsFailed++;
         $display("[TB] FAIL %s_hold: done=%b stim=%0d, required done=1 stim=3", tag, doneA, stimA);
      end
   endtask

   task automatic test_nand_good();
      modeA = 0;
      faultMaskA = '0;
      sweepA("nand_good", 1'b0);
   endtask

   task automatic test_stuck_high();
      modeA = 1;
      sweepA("stuck1", 1'b0);
   endtask

   task automatic test_stuck_low();
      modeA = 2;
      sweepA("stuck0", 1'b0);
   endtask

   task automatic test_ignored_start();
      modeA = 0;
      faultMaskA = 4'b0010;
      sweepA("ignored_start", 1'b1);
   endtask

   task automatic test_reset_mid_sweep();
      bit seen;
      modeA = 0;
      faultMaskA = 4'b0001;
      seen = 1'b0;
      @(posedge clk); #1;
      startA = 1'b1;
      @(posedge clk); #1;
      startA = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (stimA === NA'(2)) seen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("[TB] FAIL midreset_wait: stim=%0d, required to reach 2 within 20 cycles", stimA);
      end
      #2;
      applyReset();
      testsRun++;
      if (stimA !== '0 || busyA !== 1'b0 || doneA !== 1'b0 || passA !== 1'b0 ||
          errA !== '0 || ffVecA !== '0 || ffValidA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_outputs: stim=%0d busy=%b done=%b pass=%b err=%0d ffv=%0d ffvalid=%b, required all zero",
                  stimA, busyA, doneA, passA, errA, ffVecA, ffValidA);
      end
`ifdef MISMATCH_MAP_EN
      testsRun++;
      if (mapA !== '0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_map: map=%b, required 0", mapA);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      faultMaskA = '0;
      sweepA("after_reset", 1'b0);
   endtask

   task automatic test_xor_sweep(input logic [7:0] mask);
      int total;
      int expErr;
      int expFirst;
      bit expValid;
      total = 8 * (SB + 1);
      expErr = 0;
      expFirst = 0;
      expValid = 1'b0;
      faultMaskB = mask;
      for (int v = 0; v < 8; v++) begin
         if ((refXor3(v) ^ mask[v]) != refXor3(v)) begin
            expErr++;
            if (!expValid) begin
               expValid = 1'b1;
               expFirst = v;
            end
         end
      end
      @(posedge clk); #1;
      startB = 1'b1;
      @(posedge clk); #1;
      startB = 1'b0;
      for (int j = 0; j < total; j++) begin
         testsRun++;
         if (stimB !== NB'(j / (SB + 1)) || busyB !== 1'b1 || doneB !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL xor_cycle%0d: stim=%0d busy=%b done=%b, required stim=%0d busy=1 done=0",
                     j, stimB, busyB, doneB, j / (SB + 1));
         end
         @(posedge clk); #1;
      end
      testsRun++;
      if (doneB !== 1'b1 || busyB !== 1'b0 || stimB !== NB'(7) ||
          errB !== (NB+1)'(expErr) || passB !== (expErr == 0) ||
          ffValidB !== expValid || ffVecB !== NB'(expFirst)) begin
         testsFailed++;
         $display("[TB] FAIL xor_result mask=%b: done=%b busy=%b stim=%0d err=%0d pass=%b ffvalid=%b ffv=%0d, required done=1 busy=0 stim=7 err=%0d pass=%b ffvalid=%b ffv=%0d",
                  mask, doneB, busyB, stimB, errB, passB, ffValidB, ffVecB, expErr, expErr == 0, expValid, expFirst);
      end
`ifdef MISMATCH_MAP_EN
      testsRun++;
      if (mapB !== mask) begin
         testsFailed++;
         $display("[TB] FAIL xor_map: map=%b, required %b", mapB, mask);
      end
`endif
   endtask

   task automatic test_back_to_back();
      modeA = 0;
      faultMaskA = '0;
      sweepA("b2b_first", 1'b0);
      faultMaskA = 4'b0110;
      sweepA("b2b_second", 1'b0);
   endtask

   task automatic test_random_faults();
      modeA = 0;
      for (int t = 0; t < 6; t++) begin
         faultMaskA = 4'($urandom_range(0, 15));
         sweepA("rand_nand", 1'b0);
      end
      for (int t = 0; t < 3; t++) begin
         test_xor_sweep(8'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      test_reset();
      test_nand_good();
      test_stuck_high();
      test_stuck_low();
      test_ignored_start();
      test_reset_mid_sweep();
      test_xor_sweep(8'h00);
      test_back_to_back();
      test_random_faults();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
